// File: rtl/minmax_sequencer_if.sv
// Sample stream and result bus of minmax_sequencer.
// Handshake: a sample transfers on a rising edge where piValid and poReady are both high; piData must be stable while piValid is high.
interface minmax_sequencer_if #(
  parameter int N     = 8,
  parameter int LEN_W = 8
);
  logic             piStart;
  logic [LEN_W-1:0] piLen;
  logic [N-1:0]     piData;
  logic             piValid;
  logic             poReady;
  logic             poBusy;
  logic             poDone;
  logic [N-1:0]     poMax;
  logic [N-1:0]     poMin;
  logic [LEN_W-1:0] poMaxIdx;
  logic [LEN_W-1:0] poMinIdx;
  logic [LEN_W-1:0] poCount;
  logic [2:0]       dbgState;

  modport master (
    output piStart, piLen, piData, piValid,
    input  poReady, poBusy, poDone, poMax, poMin, poMaxIdx, poMinIdx, poCount, dbgState
  );

  modport slave (
    input  piStart, piLen, piData, piValid,
    output poReady, poBusy, poDone, poMax, poMin, poMaxIdx, poMinIdx, poCount, dbgState
  );
endinterface

// File: rtl/minmax_sequencer.sv
// Per-frame min/max tracker sharing one comparator between the max and min
// updates of each sample, three cycles per sample.
module comparator #(
  parameter int N = 8
) (
  input  logic [N-1:0] piA,
  input  logic [N-1:0] piB,
  output logic         poMayor,
  output logic         poMenor,
  output logic         poIgual
);
  assign poMayor = (piA > piB);
  assign poMenor = (piA < piB);
  assign poIgual = (piA == piB);
endmodule

module minmax_sequencer #(
  parameter int N     = 8,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  minmax_sequencer_if.slave     bus
);
  typedef enum logic [2:0] {IDLE, WAIT, CMP_MAX, CMP_MIN, DONE} stateT;

  stateT            state, nextState;
  logic [LEN_W-1:0] lenReg;
  logic [N-1:0]     sampleReg;
  logic [N-1:0]     maxReg, minReg;
  logic [LEN_W-1:0] maxIdxReg, minIdxReg, countReg;
  logic [LEN_W-1:0] countInc;
  logic [N-1:0]     cmpB;
  logic             mayor, menor, igual;
  logic             firstSample;

  // The single comparator sees the running max in CMP_MAX and the running min in CMP_MIN.
  assign cmpB = (state == CMP_MIN) ? minReg : maxReg;

  comparator #(.N(N)) uCmp (
    .piA    (sampleReg),
    .piB    (cmpB),
    .poMayor(mayor),
    .poMenor(menor),
    .poIgual(igual)
  );

  assign countInc    = countReg + LEN_W'(1);
  assign firstSample = (countReg == '0);

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.piStart) nextState = (bus.piLen == '0) ? DONE : WAIT;
      WAIT:    if (bus.piValid) nextState = CMP_MAX;
      CMP_MAX: nextState = CMP_MIN;
      CMP_MIN: nextState = (countInc == lenReg) ? DONE : WAIT;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lenReg    <= '0;
      sampleReg <= '0;
      maxReg    <= '0;
      minReg    <= '0;
      maxIdxReg <= '0;
      minIdxReg <= '0;
      countReg  <= '0;
    end else begin
      state <= nextState;
      unique case (state)
        IDLE: begin
          if (bus.piStart) begin
            lenReg    <= bus.piLen;
            maxReg    <= '0;
            minReg    <= '0;
            maxIdxReg <= '0;
            minIdxReg <= '0;
            countReg  <= '0;
          end
        end
        WAIT: if (bus.piValid) sampleReg <= bus.piData;
        // Ties never update, so the first occurrence keeps its index.
        CMP_MAX: begin
          if (firstSample || (mayor && !igual)) begin
            maxReg    <= sampleReg;
            maxIdxReg <= countReg;
          end
        end
        CMP_MIN: begin
          if (firstSample || (menor && !igual)) begin
            minReg    <= sampleReg;
            minIdxReg <= countReg;
          end
          countReg <= countInc;
        end
        default: ;
      endcase
    end
  end

  assign bus.poReady  = (state == WAIT);
  assign bus.poBusy   = (state != IDLE);
  assign bus.poDone   = (state == DONE);
  assign bus.poMax    = maxReg;
  assign bus.poMin    = minReg;
  assign bus.poMaxIdx = maxIdxReg;
  assign bus.poMinIdx = minIdxReg;
  assign bus.poCount  = countReg;
  assign bus.dbgState = state;
endmodule

// File: tb/tb_minmax_sequencer.sv
// Bench for minmax_sequencer: directed vector table, reset and noise sequences,
// and randomized frames scored against a first-occurrence min/max model.
module tb_minmax_sequencer;
  localparam int N     = 8;
  localparam int LEN_W = 8;
  localparam int W     = 2 * N + 3 * LEN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  minmax_sequencer_if #(.N(N), .LEN_W(LEN_W)) bus ();

  minmax_sequencer #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int sample_q[$];

  typedef struct {
    int len;
    int s0, s1, s2, s3, s4;
    int max_e, max_idx_e, min_e, min_idx_e;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference: scan the first `upto` samples, replacing only on strictly larger/smaller.
  function automatic logic [W-1:0] model(input int upto);
    int mx = 0, mn = 0, mxi = 0, mni = 0;
    for (int j = 0; j < upto; j++) begin
      if (j == 0 || sample_q[j] > mx) begin mx = sample_q[j]; mxi = j; end
      if (j == 0 || sample_q[j] < mn) begin mn = sample_q[j]; mni = j; end
    end
    return {N'(mx), N'(mn), LEN_W'(mxi), LEN_W'(mni), LEN_W'(upto)};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.poMax, bus.poMin, bus.poMaxIdx, bus.poMinIdx, bus.poCount};
  endfunction

  task automatic run_frame(input int len, input int gap_max, input bit noise);
    logic [W-1:0] exp_w, m_now, m_prev;
    @(negedge clk);
    check("idle_busy", 64'(bus.poBusy), 64'd0);
    bus.piStart = 1'b1;
    bus.piLen   = LEN_W'(len);
    exp_q.push_back(model(len));
    exp_w = model(len);
    @(negedge clk);
    bus.piStart = 1'b0;
    if (len == 0) begin
      check("zero_done", 64'(bus.poDone), 64'd1);
      check("zero_ready", 64'(bus.poReady), 64'd0);
      check("frame_result", 64'(observed()), 64'(exp_q.pop_front()));
    end else begin
      check("start_busy", 64'(bus.poBusy), 64'd1);
      for (int i = 0; i < len; i++) begin
        int gap;
        gap = $urandom_range(0, gap_max);
        for (int g = 0; g < gap; g++) begin
          check("wait_ready", 64'(bus.poReady), 64'd1);
          bus.piValid = 1'b0;
          bus.piStart = noise;
          bus.piData  = N'($urandom_range(0, 255));
          @(negedge clk);
        end
        check("accept_ready", 64'(bus.poReady), 64'd1);
        bus.piValid = 1'b1;
        bus.piStart = 1'b0;
        bus.piData  = N'(sample_q[i]);
        @(negedge clk);
        check("cmp_ready", 64'(bus.poReady), 64'd0);
        bus.piValid = noise;
        bus.piStart = noise;
        bus.piData  = N'($urandom_range(0, 255));
        @(negedge clk);
        m_now  = model(i + 1);
        m_prev = model(i);
        check("mid_max", 64'({bus.poMax, bus.poMaxIdx}),
              64'({m_now[W-1 -: N], m_now[3*LEN_W-1 -: LEN_W]}));
        check("mid_min", 64'({bus.poMin, bus.poMinIdx, bus.poCount}),
              64'({m_prev[W-N-1 -: N], m_prev[2*LEN_W-1 -: LEN_W], m_prev[LEN_W-1:0]}));
        bus.piData = N'($urandom_range(0, 255));
        @(negedge clk);
        bus.piValid = 1'b0;
        bus.piStart = 1'b0;
        check("done_flag", 64'(bus.poDone), (i == len - 1) ? 64'd1 : 64'd0);
        if (i == len - 1) check("frame_result", 64'(observed()), 64'(exp_q.pop_front()));
      end
    end
    @(negedge clk);
    check("done_pulse", 64'(bus.poDone), 64'd0);
    check("end_idle", 64'(bus.poBusy), 64'd0);
    check("hold_result", 64'(observed()), 64'(exp_w));
  endtask

  task automatic load_vec(input vec_t v);
    int s[5];
    s = '{v.s0, v.s1, v.s2, v.s3, v.s4};
    sample_q.delete();
    for (int k = 0; k < v.len; k++) sample_q.push_back(s[k]);
  endtask

  task automatic check_vec(input string name, input vec_t v);
    check(name, 64'(observed()),
          64'({N'(v.max_e), N'(v.min_e), LEN_W'(v.max_idx_e), LEN_W'(v.min_idx_e), LEN_W'(v.len)}));
  endtask

  initial begin
    vecs[0] = '{4, 7, 3, 9, 3, 0, 9, 2, 3, 1};
    vecs[1] = '{3, 5, 5, 5, 0, 0, 5, 0, 5, 0};
    vecs[2] = '{1, 255, 0, 0, 0, 0, 255, 0, 255, 0};
    vecs[3] = '{5, 0, 255, 128, 0, 255, 255, 1, 0, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    bus.piStart = 1'b0;
    bus.piLen   = '0;
    bus.piData  = '0;
    bus.piValid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({observed(), bus.poReady, bus.poBusy, bus.poDone}), 64'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      load_vec(vecs[k]);
      run_frame(vecs[k].len, 0, 1'b0);
      check_vec($sformatf("vec%0d", k), vecs[k]);
    end

    // Same basic frame with gaps and stray start/valid during compare cycles.
    for (int r = 0; r < 3; r++) begin
      load_vec(vecs[0]);
      run_frame(4, 5, 1'b1);
      check_vec("gap_noise", vecs[0]);
    end

    // Reset mid-frame after two samples.
    @(negedge clk);
    bus.piStart = 1'b1;
    bus.piLen   = LEN_W'(4);
    @(negedge clk);
    bus.piStart = 1'b0;
    bus.piValid = 1'b1;
    bus.piData  = N'(7);
    @(negedge clk);
    bus.piValid = 1'b0;
    repeat (2) @(negedge clk);
    bus.piValid = 1'b1;
    bus.piData  = N'(3);
    @(negedge clk);
    bus.piValid = 1'b0;
    @(negedge clk);
    check("pre_reset_max", 64'(bus.poMax), 64'd7);
    check("pre_reset_busy", 64'(bus.poBusy), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_reset_outputs", 64'({observed(), bus.poReady, bus.poBusy, bus.poDone}), 64'd0);
    rst = 1'b0;
    load_vec(vecs[0]);
    run_frame(4, 0, 1'b0);
    check_vec("after_reset", vecs[0]);

    // Randomized frames, some with a narrow value range to force ties.
    for (int f = 0; f < 25; f++) begin
      int len, hi;
      len = $urandom_range(1, 12);
      hi  = ($urandom_range(0, 1) == 1) ? 3 : 255;
      sample_q.delete();
      for (int k = 0; k < len; k++) sample_q.push_back($urandom_range(0, hi));
      run_frame(len, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/minmax_sequencer.md
# minmax_sequencer

Frame-based min/max tracker that time-shares a single instance of the `comparator` block, parameter N, across a stream of samples. A frame is started with a length. Samples are accepted through a valid/ready handshake. Each sample is compared against the running maximum and then the running minimum on consecutive cycles, with one comparator muxed between the two. The block reports min, max, their first-occurrence indices and a done pulse. It sits between a sample producer (ADC/UART front end) and any consumer that needs per-frame extremes.

## Interface
Parameters:
- N, default 8: sample width, passed to the internal comparator.
- LEN_W, default 8: width of the frame length, sample count and index outputs.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- piStart, input, 1: begins a frame; sampled only in IDLE.
- piLen, input, LEN_W: number of samples in the frame; latched when piStart is accepted.
- piData, input, N: sample, unsigned.
- piValid, input, 1: piData is valid.
- poReady, output, 1: block accepts a sample this cycle.
- poBusy, output, 1: a frame is in progress (any state other than IDLE).
- poDone, output, 1: one-cycle pulse marking the end of a frame.
- poMax, output, N: running/final maximum.
- poMin, output, N: running/final minimum.
- poMaxIdx, output, LEN_W: 0-based index of the first occurrence of poMax.
- poMinIdx, output, LEN_W: 0-based index of the first occurrence of poMin.
- poCount, output, LEN_W: number of samples fully processed in the current or last frame.

## Operation
- Internal datapath:
  - Exactly one comparator #(N) instance.
  - piA is the captured sample register.
  - piB is poMax in CMP_MAX and poMin in CMP_MIN.
  - No other magnitude comparison on samples is allowed.
- FSM states: IDLE, WAIT, CMP_MAX, CMP_MIN, DONE.
- IDLE:
  - poReady=0, poBusy=0.
  - On piStart=1: latch piLen and clear poCount, poMax, poMin, poMaxIdx and poMinIdx to 0.
  - Then go to WAIT if piLen!=0, or to DONE if piLen==0.
- WAIT:
  - poReady=1.
  - On piValid=1, capture piData into the sample register and go to CMP_MAX. Otherwise stay.
- CMP_MAX:
  - If poCount==0 or poMayor=1: poMax<=sample and poMaxIdx<=poCount.
  - Ties (poIgual) do not update, so the earliest index is kept.
  - Go to CMP_MIN.
- CMP_MIN:
  - If poCount==0 or poMenor=1: poMin<=sample and poMinIdx<=poCount.
  - Always poCount<=poCount+1.
  - Go to DONE if poCount+1==latched length, else go to WAIT.
- DONE: poDone=1 for exactly this cycle, then go to IDLE.
- Results hold their values in IDLE until the next accepted piStart.
- piStart outside IDLE is ignored, with no effect on the frame in progress.
- piData/piValid outside WAIT are ignored; no sample is lost or double-counted.
- poCount wrap: impossible, since the length is at most 2^LEN_W-1.
- Arithmetic: poCount+1 is compared at LEN_W bits.
- Reset: rst=1 at any cycle, including mid-frame, forces IDLE next edge.
  - All outputs go to 0: poReady, poBusy, poDone, poMax, poMin, poMaxIdx, poMinIdx, poCount.
  - The latched length and sample register also clear.
- rst has priority over every other input.

## Timing
- piStart sampled high in IDLE at edge t: WAIT from cycle t+1, with poReady=1 and poBusy=1.
- Sample handshake at edge a (WAIT, piValid=1):
  - CMP_MAX during a+1.
  - CMP_MIN during a+2.
  - Updated poMax/poMaxIdx visible from a+2.
  - Updated poMin/poMinIdx/poCount visible from a+3.
- Next readiness: WAIT with poReady=1 again at a+3. Peak throughput is 1 sample per 3 cycles.
- Last sample accepted at edge a: DONE during a+3 (poDone=1, final results valid), IDLE at a+4.
- piLen==0: start at t, DONE at t+1 with all results 0, IDLE at t+2.
- poDone is never high for more than one consecutive cycle.

## Test plan
- Reset: hold rst 2 cycles mid-frame after 2 samples → next cycle all outputs 0, IDLE; a new piStart works normally.
- Basic frame, N=8, piLen=4, samples 7,3,9,3 with piValid always high:
  - poMax=9, poMaxIdx=2, poMin=3, poMinIdx=1 (first occurrence), poCount=4.
  - poDone one cycle; handshakes exactly 3 cycles apart.
- Ties and single-sample frame:
  - piLen=3, samples 5,5,5 → poMax=poMin=5, both indices 0.
  - piLen=1, sample 255 → poMax=poMin=255, poDone at accept+3.
- Zero length: piLen=0 → poDone one cycle after start, results 0, no poReady asserted.
- Backpressure/ignored inputs:
  - Gaps of 0–5 cycles in piValid → identical results to the gapless run.
  - piStart pulsed mid-frame and piValid held high during CMP states → no extra samples, frame unaffected.
- Extremes: N=8, samples 0,255,128,0,255 → poMax=255 idx 1, poMin=0 idx 0, poCount=5.
